// File: rtl/filtro_secuenciador_pkg.sv
// ============================================================================
// Module      : filtro_secuenciador_pkg
// Description : Shared definitions for the band-pass cascade sample-rate
//               controller. Holds the default sample width (the cascade
//               uses the same width) and the controller state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package filtro_secuenciador_pkg;

    // Sample width shared with the 20 Hz HP -> 200 Hz LP cascade.
    localparam int c_w_default = 25;

    // Controller states, explicitly encoded in 3 bits.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TICK = 3'd1,
        S_REQ       = 3'd2,
        S_EN        = 3'd3,
        S_SETTLE    = 3'd4
    } state_t;

    // True while a sample is in flight; a tick landing here is a miss.
    function automatic logic is_busy(input state_t s);
        return (s == S_REQ) || (s == S_EN) || (s == S_SETTLE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/filtro_tick_gen.sv
// ============================================================================
// Module      : filtro_tick_gen
// Description : Sample-period divider. Counts 0..DIV-1 and wraps; o_tick is
//               high while the count sits at DIV-1. i_clr holds the count
//               at 0.
// Ports       : clk    in  system clock
//               rst    in  synchronous active-high reset
//               i_clr  in  synchronous clear / hold at 0
//               o_tick out one-cycle tick every DIV cycles
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filtro_tick_gen #(
    parameter int DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int                c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0]   c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cw'(1);
        end
    end

    assign o_tick = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/filtro_secuenciador.sv
// ============================================================================
// Module      : filtro_secuenciador
// Description : Sample-rate controller for the band-pass cascade. Requests
//               one ADC conversion per sample tick, strobes the sample into
//               the cascade, waits the settle time, captures the cascade
//               output and offers it on a valid/ready handshake.
// Ports       : CLK, Reset (sync, active high), Run (sampling enable level)
//               adc_req/adc_valid/adc_data   ADC conversion interface
//               filt_u/filt_en/filt_clr/filt_y cascade interface
//               y_out/y_valid/y_ready        downstream handshake
//               sample_miss, overrun         one-cycle event pulses
//               sat_flag                     sticky saturation flag
// Config      : SAT_MON_EN - when defined, sat_flag latches on a captured
//               full-scale sample; otherwise sat_flag is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module filtro_secuenciador
    import filtro_secuenciador_pkg::*;
#(
    parameter int W      = c_w_default,
    parameter int DIV    = 5000,
    parameter int SETTLE = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Run,
    output logic         adc_req,
    input  logic         adc_valid,
    input  logic [W-1:0] adc_data,
    output logic [W-1:0] filt_u,
    output logic         filt_en,
    output logic         filt_clr,
    input  logic [W-1:0] filt_y,
    output logic [W-1:0] y_out,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         sample_miss,
    output logic         overrun,
    output logic         sat_flag
);

    // The settle counter also runs during EN, so the capture edge lands
    // exactly SETTLE cycles after the filt_en strobe. SETTLE == 1 captures
    // straight out of EN.
    localparam int              c_sw          = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [c_sw-1:0] c_settle_load = c_sw'((SETTLE >= 2) ? SETTLE - 2 : 0);
    localparam bit              c_settle_one  = (SETTLE == 1);

    state_t          r_state, w_state_nxt;
    logic [c_sw-1:0] r_settle, w_settle_nxt;
    logic            w_tick;
    logic            w_start;
    logic            w_accept;
    logic            w_capture;
    logic            w_timer_clr;

    logic [W-1:0]    r_filt_u;
    logic [W-1:0]    r_y_out;
    logic            r_y_valid;
    logic            r_filt_clr;
    logic            r_miss;
    logic            r_overrun;

    assign w_timer_clr = (r_state == S_IDLE);

    filtro_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (CLK),
        .rst    (Reset),
        .i_clr  (w_timer_clr),
        .o_tick (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        w_start      = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Run) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (!Run) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                // Run dropping abandons the pending conversion.
                if (!Run) begin
                    w_state_nxt = S_IDLE;
                end else if (adc_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EN;
                end
            end
            S_EN: begin
                w_settle_nxt = c_settle_load;
                if (c_settle_one) begin
                    w_capture   = 1'b1;
                    w_state_nxt = Run ? S_WAIT_TICK : S_IDLE;
                end else begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = Run ? S_WAIT_TICK : S_IDLE;
                end else begin
                    w_settle_nxt = r_settle - c_sw'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_settle   <= '0;
            r_filt_u   <= '0;
            r_y_out    <= '0;
            r_y_valid  <= 1'b0;
            r_filt_clr <= 1'b0;
            r_miss     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_settle   <= w_settle_nxt;
            r_filt_clr <= w_start;
            // A tick while a sample is in flight is dropped, state untouched.
            r_miss     <= w_tick && is_busy(r_state);
            // Overwriting a value nobody accepted this cycle is an overrun;
            // a same-cycle transfer means the old value was delivered.
            r_overrun  <= w_capture && r_y_valid && !y_ready;
            if (w_accept) begin
                r_filt_u <= adc_data;
            end
            if (w_capture) begin
                r_y_out   <= filt_y;
                r_y_valid <= 1'b1;
            end else if (r_y_valid && y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

`ifdef SAT_MON_EN
    localparam logic [W-1:0] c_pos_fs = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_neg_fs = {1'b1, {(W-1){1'b0}}};

    logic r_sat;

    always_ff @(posedge CLK) begin
        if (Reset || w_start) begin
            r_sat <= 1'b0;
        end else if (w_capture && ((filt_y == c_pos_fs) || (filt_y == c_neg_fs))) begin
            r_sat <= 1'b1;
        end
    end

    assign sat_flag = r_sat;
`else
    assign sat_flag = 1'b0;
`endif

    assign adc_req     = (r_state == S_REQ);
    assign filt_en     = (r_state == S_EN);
    assign filt_clr    = r_filt_clr;
    assign filt_u      = r_filt_u;
    assign y_out       = r_y_out;
    assign y_valid     = r_y_valid;
    assign sample_miss = r_miss;
    assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_filtro_secuenciador.sv
// ============================================================================
// Module      : tb_filtro_secuenciador
// Description : Self-checking bench for filtro_secuenciador (DIV=20,
//               SETTLE=3, W=25). Expected timing is derived from the run
//               start cycle and the sample period; expected data comes from
//               the values the bench drives. SAT_MON_EN selects the
//               saturation-flag expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filtro_secuenciador;

    localparam int W      = 25;
    localparam int DIV    = 20;
    localparam int SETTLE = 3;
    localparam logic [W-1:0] c_max = W'((2 ** (W - 1)) - 1);
    localparam logic [W-1:0] c_min = W'(2 ** (W - 1));
`ifdef SAT_MON_EN
    localparam bit c_sat_on = 1'b1;
`else
    localparam bit c_sat_on = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         Reset, Run, adc_valid, y_ready;
    logic [W-1:0] adc_data, filt_y;
    logic         adc_req, filt_en, filt_clr, y_valid, sample_miss, overrun, sat_flag;
    logic [W-1:0] filt_u, y_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int c0    = 0;
    bit exp_valid = 1'b0;
    bit exp_sat   = 1'b0;

    always #5 CLK = ~CLK;

    filtro_secuenciador #(.W(W), .DIV(DIV), .SETTLE(SETTLE)) dut (
        .CLK(CLK), .Reset(Reset), .Run(Run),
        .adc_req(adc_req), .adc_valid(adc_valid), .adc_data(adc_data),
        .filt_u(filt_u), .filt_en(filt_en), .filt_clr(filt_clr), .filt_y(filt_y),
        .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
        .sample_miss(sample_miss), .overrun(overrun), .sat_flag(sat_flag)
    );

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_y();
        logic [W-1:0] v;
        v = W'($urandom);
        if (v == c_max || v == c_min) v = v ^ W'(1);
        return v;
    endfunction

    // Sampling starts: filt_clr appears the next cycle, timer starts at 0 there.
    task automatic start_run();
        Run = 1'b1;
        step();
        chk("filt_clr_pulse", filt_clr, 1);
        c0 = cyc;
        exp_sat = 1'b0;
        chk("sat_cleared_on_clr", sat_flag, 0);
        step();
        chk("filt_clr_one_cycle", filt_clr, 0);
    endtask

    // adc_req rises on the first multiple of DIV after the run start.
    task automatic wait_req();
        int exp_c;
        int guard;
        exp_c = c0 + ((cyc - c0) / DIV + 1) * DIV;
        guard = 0;
        while (adc_req !== 1'b1 && guard < 3 * DIV) begin
            step();
            guard++;
        end
        chk("req_cycle", cyc, exp_c);
    endtask

    task automatic drain();
        y_ready = 1'b1;
        step();
        chk("y_valid_after_accept", y_valid, 0);
        y_ready = 1'b0;
        exp_valid = 1'b0;
    endtask

    // Entered on the cycle adc_req is first seen high; returns SETTLE+1
    // cycles after filt_en. y_ready is high only on the capture cycle,
    // and only when rdy_cap is set.
    task automatic do_sample(input int lat, input logic [W-1:0] d, input logic [W-1:0] y,
                             input bit rdy_cap, input bit drop_run);
        bit exp_ovr;
        for (int i = 0; i < lat; i++) begin
            step();
            chk("adc_req_held", adc_req, 1);
            chk("sample_miss", sample_miss, ((cyc - c0) % DIV) == 0);
        end
        adc_valid = 1'b1;
        adc_data  = d;
        step();
        adc_valid = 1'b0;
        adc_data  = W'($urandom);
        chk("filt_en_rise", filt_en, 1);
        chk("adc_req_drop", adc_req, 0);
        chk("filt_u", filt_u, d);
        filt_y = y;
        step();
        chk("filt_en_one_cycle", filt_en, 0);
        if (drop_run) Run = 1'b0;
        for (int i = 2; i < SETTLE; i++) step();
        chk("y_valid_before_capture", y_valid, exp_valid);
        y_ready = rdy_cap;
        exp_ovr = exp_valid && !rdy_cap;
        step();
        y_ready = 1'b0;
        chk("y_valid_at_capture", y_valid, 1);
        chk("y_out", y_out, y);
        chk("overrun_pulse", overrun, exp_ovr);
        exp_valid = 1'b1;
        if (c_sat_on && (y == c_max || y == c_min)) exp_sat = 1'b1;
        chk("sat_flag", sat_flag, exp_sat);
        filt_y = W'($urandom);
        step();
        chk("overrun_one_cycle", overrun, 0);
        chk("y_valid_held", y_valid, 1);
        chk("y_out_held", y_out, y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Run = 1'b0; adc_valid = 1'b0; y_ready = 1'b0;
        adc_data = '0; filt_y = '0;
        repeat (3) step();
        Reset = 1'b0;
        step();
        chk("rst_adc_req", adc_req, 0);
        chk("rst_filt_en", filt_en, 0);
        chk("rst_filt_clr", filt_clr, 0);
        chk("rst_filt_u", filt_u, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_miss", sample_miss, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_timer", dut.u_tick_gen.r_count, 0);

        // Nominal sample.
        start_run();
        wait_req();
        do_sample(0, 25'h000123, 25'h1FFF00, 1'b0, 1'b0);
        drain();

        // Random samples, random accept behaviour.
        for (int k = 0; k < 4; k++) begin
            wait_req();
            do_sample(int'($urandom_range(0, 8)), W'($urandom), rnd_y(),
                      bit'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 1) == 1) drain();
        end
        if (exp_valid) drain();

        // Backpressure: two captures without accept, then a capture that
        // coincides with an accept.
        wait_req();
        do_sample(int'($urandom_range(0, 8)), W'($urandom), rnd_y(), 1'b0, 1'b0);
        wait_req();
        do_sample(int'($urandom_range(0, 8)), W'($urandom), rnd_y(), 1'b0, 1'b0);
        wait_req();
        do_sample(int'($urandom_range(0, 8)), W'($urandom), rnd_y(), 1'b1, 1'b0);
        drain();

        // Slow ADC: one tick lands while still requesting.
        wait_req();
        do_sample(25, W'($urandom), rnd_y(), 1'b0, 1'b0);
        drain();

        // Full-scale positive capture, then a normal one with Run dropping.
        wait_req();
        do_sample(2, W'($urandom), c_max, 1'b0, 1'b0);
        drain();
        wait_req();
        do_sample(1, W'($urandom), rnd_y(), 1'b0, 1'b1);
        for (int i = 0; i < 2 * DIV; i++) begin
            chk("idle_no_req", adc_req, 0);
            chk("idle_timer", dut.u_tick_gen.r_count, 0);
            step();
        end
        chk("sat_held_idle", sat_flag, exp_sat);

        // Restart clears sat; full-scale negative capture.
        start_run();
        wait_req();
        do_sample(3, W'($urandom), c_min, 1'b0, 1'b0);

        // Reset in the middle of SETTLE.
        wait_req();
        adc_valid = 1'b1;
        adc_data  = W'($urandom);
        step();
        adc_valid = 1'b0;
        chk("pre_reset_filt_en", filt_en, 1);
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Run   = 1'b0;
        chk("mid_rst_filt_en", filt_en, 0);
        chk("mid_rst_adc_req", adc_req, 0);
        chk("mid_rst_filt_u", filt_u, 0);
        chk("mid_rst_y_out", y_out, 0);
        chk("mid_rst_y_valid", y_valid, 0);
        chk("mid_rst_sat", sat_flag, 0);
        chk("mid_rst_overrun", overrun, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("post_rst_filt_en", filt_en, 0);
            chk("post_rst_y_valid", y_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
